// File: rtl/bus_timer.sv
// Bus-mapped down-counting timer with one-shot / auto-reload modes and a maskable IRQ.
// Optional 8-bit tick prescaler on Addr 3 when TIMER_PRESCALE_EN is defined.
module bus_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t           state, state_nxt;
  logic             en, im, pending;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset, count;
  logic [31:0]      prescale_rd;
  logic             wr_ctrl, wr_preset, tick, reload;
  logic             load_cnt, dec_cnt, set_pend, clr_en;

  assign wr_ctrl   = Sel && We && (Addr == 2'd0);
  assign wr_preset = Sel && We && (Addr == 2'd1);
  // Only MODE=01 reloads; the reserved encodings behave as one-shot.
  assign reload    = (mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale, div;
  logic       wr_prescale;

  assign wr_prescale = Sel && We && (Addr == 2'd3);
  assign tick        = (div == prescale);
  assign prescale_rd = {24'd0, prescale};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      div      <= '0;
    end else begin
      if (wr_prescale) prescale <= DIn[7:0];
      if (state == LOAD)     div <= '0;
      else if (state == CNT) div <= tick ? 8'd0 : div + 8'd1;
    end
  end
`else
  assign tick        = 1'b1;
  assign prescale_rd = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    set_pend  = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: begin
        load_cnt  = 1'b1;
        state_nxt = (preset == '0) ? INT : CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tick) begin
          dec_cnt = 1'b1;
          if (count <= CNT_W'(1)) state_nxt = INT;
        end
      end
      INT: begin
        set_pend = 1'b1;
        if (reload) begin
          state_nxt = LOAD;
        end else begin
          clr_en    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A bus write to CTRL takes priority over the FSM's EN clear and pending set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      pending <= 1'b0;
      preset  <= '0;
      count   <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= DIn[0];
        mode <= DIn[2:1];
        im   <= DIn[3];
      end else if (clr_en) begin
        en <= 1'b0;
      end

      if (wr_ctrl)               pending <= 1'b0;
      else if (set_pend)         pending <= 1'b1;
      else if (pending && reload) pending <= 1'b0;

      if (wr_preset) preset <= DIn[CNT_W-1:0];

      if (load_cnt)     count <= preset;
      else if (dec_cnt) count <= count - CNT_W'(1);
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      2'd0:    DOut = {28'd0, im, mode, en};
      2'd1:    DOut = 32'(preset);
      2'd2:    DOut = 32'(count);
      default: DOut = prescale_rd;
    endcase
  end

  assign IRQ = pending & im;

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer (default build; prescaler test when TIMER_PRESCALE_EN is defined).
module tb_bus_timer;

  logic        clk;
  logic        rst;
  logic        Sel;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  bus_timer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Sel(Sel), .Addr(Addr), .We(We),
    .DIn(DIn), .DOut(DOut), .IRQ(IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a write at the negedge; the write lands on the next posedge, returns at posedge+1.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Sel = 1'b1; We = 1'b1; Addr = a; DIn = d;
    @(posedge clk);
    #1;
    Sel = 1'b0; We = 1'b0; DIn = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOut;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected 0", a, d);
      end
    end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h9);
    Addr = 2'd2;
    step();
    step();
    n_checks++;
    if (DOut !== 32'd5) begin n_fail++; $display("FAIL oneshot_load: got %0d expected 5", DOut); end
    for (int i = 4; i >= 0; i--) begin
      step();
      n_checks++;
      if (DOut !== 32'(i)) begin n_fail++; $display("FAIL oneshot_count: got %0d expected %0d", DOut, i); end
    end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_in_int: got %b expected 0", IRQ); end
    step();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b expected 1", IRQ); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_en_clr: got %h expected 8", d); end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %b expected 1", IRQ); end
    bus_write(2'd0, 32'h0);
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clr: got %b expected 0", IRQ); end
  endtask

  task automatic test_reload();
    logic exp;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      step();
      exp = (k >= 6) && (((k - 6) % 5) == 0);
      n_checks++;
      if (IRQ !== exp) begin n_fail++; $display("FAIL reload_irq_c%0d: got %b expected %b", k, IRQ, exp); end
    end
    bus_write(2'd0, 32'h0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (IRQ !== 1'b0) begin n_fail++; $display("FAIL mask_irq_c%0d: got %b expected 0", k, IRQ); end
    end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mask_en_clr: got %h expected 0", d); end
    bus_write(2'd0, 32'h9);
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL mask_unmask_irq: got %b expected 0", IRQ); end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (IRQ !== (k == 5)) begin n_fail++; $display("FAIL mask_rerun_c%0d: got %b expected %b", k, IRQ, (k == 5)); end
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    // PRESET=0: INT two cycles after the CTRL write
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    step();
    step();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL zero_irq_early: got %b expected 0", IRQ); end
    step();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL zero_irq: got %b expected 1", IRQ); end
    bus_write(2'd0, 32'h0);
    // CTRL write in the INT cycle: write beats EN clear and pending set
    bus_write(2'd0, 32'h9);
    step();
    step();
    bus_write(2'd0, 32'h9);
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL collide_pend: got %b expected 0", IRQ); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h9) begin n_fail++; $display("FAIL collide_ctrl: got %h expected 9", d); end
    step();
    step();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL collide_rerun_early: got %b expected 0", IRQ); end
    step();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL collide_rerun_irq: got %b expected 1", IRQ); end
    bus_write(2'd0, 32'h0);
    // Reserved CTRL bits ignored
    bus_write(2'd0, 32'hFFFF_FFF0);
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_reserved: got %h expected 0", d); end
    // PRESET write and COUNT write during counting
    bus_write(2'd1, 32'd12);
    bus_write(2'd0, 32'h1);
    Addr = 2'd2;
    step();
    step();
    step();
    bus_write(2'd1, 32'd7);
    Addr = 2'd2;
    #1;
    n_checks++;
    if (DOut !== 32'd10) begin n_fail++; $display("FAIL preset_midcount: got %0d expected 10", DOut); end
    bus_write(2'd2, 32'h1234);
    #1;
    n_checks++;
    if (DOut !== 32'd9) begin n_fail++; $display("FAIL count_write_ignored: got %0d expected 9", DOut); end
    rd(2'd1, d);
    n_checks++;
    if (d !== 32'd7) begin n_fail++; $display("FAIL preset_readback: got %0d expected 7", d); end
    for (int i = 0; i < 12; i++) step();
    bus_write(2'd0, 32'h1);
    Addr = 2'd2;
    step();
    step();
    n_checks++;
    if (DOut !== 32'd7) begin n_fail++; $display("FAIL preset_next_load: got %0d expected 7", DOut); end
    bus_write(2'd0, 32'h0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h9);
    Addr = 2'd2;
    for (int i = 0; i < 62; i++) step();
    n_checks++;
    if (DOut !== 32'd40) begin n_fail++; $display("FAIL midcount_value: got %0d expected 40", DOut); end
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_reg%0d: got %h expected 0", a, d); end
    end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", IRQ); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL no_resume_count: got %0d expected 0", d); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL no_resume_ctrl: got %h expected 0", d); end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    bus_write(2'd3, 32'd3);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL prescale_readback: got %0d expected 3", d); end
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'h9);
    Addr = 2'd2;
    step();
    for (int k = 2; k <= 11; k++) begin
      step();
      exp_cnt = (k < 6) ? 32'd2 : ((k < 10) ? 32'd1 : 32'd0);
      n_checks++;
      if (DOut !== exp_cnt) begin n_fail++; $display("FAIL prescale_count_c%0d: got %0d expected %0d", k, DOut, exp_cnt); end
      n_checks++;
      if (IRQ !== (k == 11)) begin n_fail++; $display("FAIL prescale_irq_c%0d: got %b expected %b", k, IRQ, (k == 11)); end
    end
    bus_write(2'd0, 32'h0);
  endtask
`else
  task automatic test_prescale();
    logic [31:0] d;
    bus_write(2'd3, 32'hFF);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL prescale_absent: got %h expected 0", d); end
  endtask
`endif

  initial begin
    rst = 1'b0; Sel = 1'b0; We = 1'b0; Addr = 2'd0; DIn = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_boundary();
    test_prescale();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the PRESET and COUNT registers (range 2..32; zero-extended to 32 bits on read).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Sel  input  1  device select decoded by the processor bus bridge.
REQ-005 SHALL have port Addr  input  2  register select, equal to PrAddr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=PRESCALE.
REQ-006 SHALL have port We  input  1  write enable (processor Wen).
REQ-007 SHALL have port DIn  input  32  write data (processor PrDOut).
REQ-008 SHALL have port DOut  output  32  read data (processor PrDIn).
REQ-009 SHALL have port IRQ  output  1  interrupt request, wired to one HWInt bit.

Function
REQ-010 SHALL use the following CTRL fields: [0] EN (count enable), [2:1] MODE (00 = one-shot, 01 = auto-reload, 10/11 treated as 00), [3] IM (interrupt mask); bits [31:4] read as 0.
REQ-011 SHALL update a register on the rising clk edge when Sel=1 and We=1; writes to COUNT and to reserved CTRL bits SHALL be ignored.
REQ-012 SHALL drive DOut combinationally from Addr in the same cycle, regardless of Sel.
REQ-013 SHALL implement four FSM states: IDLE, LOAD, CNT, INT.
REQ-014 IDLE SHALL move to LOAD on the first cycle in which EN=1.
REQ-015 LOAD SHALL, in one cycle, copy PRESET to COUNT and then move to CNT; if PRESET=0 it SHALL move directly to INT.
REQ-016 CNT SHALL decrement COUNT by 1 on every tick; on the tick where COUNT=1 it SHALL set COUNT=0 and move to INT.
REQ-017 CNT SHALL return to IDLE one cycle after EN is cleared; COUNT SHALL hold its value.
REQ-018 INT SHALL set the pending flag and then act by mode:
  - mode 00: clear EN and go to IDLE;
  - mode 01: go to LOAD (reload period = PRESET+2 ticks in total).
REQ-019 The pending flag SHALL behave by mode:
  - mode 00: stays set until the next CTRL write;
  - mode 01: lasts exactly one cycle.
REQ-020 IRQ SHALL equal pending AND IM, driven combinationally from registered state.
REQ-021 A PRESET write during CNT SHALL NOT affect the current count and SHALL take effect at the next LOAD.
REQ-022 When a CTRL write and the INT-state EN clear occur in the same cycle, the bus write SHALL win.
REQ-023 When a CTRL write and pending-set occur in the same cycle, the pending flag SHALL be cleared.

Reset
REQ-024 On rst=0, CTRL, PRESET, COUNT, PRESCALE and pending SHALL be cleared immediately and the FSM SHALL enter IDLE; IRQ=0 and DOut reflects the zeroed registers.
REQ-025 Reset released in mid-count SHALL resume only after EN is rewritten.

Configuration
REQ-026 With TIMER_PRESCALE_EN defined:
  - Addr 3 SHALL be an 8-bit read/write PRESCALE register;
  - a tick SHALL occur once every PRESCALE+1 clk cycles, counted by an internal divider that restarts in LOAD.
REQ-027 With TIMER_PRESCALE_EN undefined:
  - a tick SHALL occur on every clk cycle;
  - Addr 3 SHALL read 0 and ignore writes;
  - no divider logic SHALL be synthesized.

Verification
REQ-028 One-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on consecutive cycles after LOAD; IRQ=1 from the cycle after INT; EN reads 0; IRQ stays high until a CTRL write of 0x0.
REQ-029 Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses 1 cycle high every 5 cycles, for 4 periods.
REQ-030 Mask: PRESET=2, CTRL=0x1 -> pending is set but IRQ stays 0; a later CTRL write of 0x9 leaves IRQ 0 because the write clears pending.
REQ-031 Boundary cases:
  - PRESET=0, CTRL=0x9 -> INT is reached 2 cycles after the write;
  - a COUNT write of 0x1234 is ignored;
  - a PRESET write of 7 during counting leaves the current count unaffected.
REQ-032 Reset mid-count: PRESET=100, pull rst low at COUNT=40 -> all registers read 0 and IRQ=0 at once; no further count after release.
REQ-033 TIMER_PRESCALE_EN: PRESCALE=3, PRESET=2, CTRL=0x9 -> COUNT changes every 4 cycles; IRQ is asserted 8-9 cycles after LOAD.
